// File: rtl/seg_scan_display.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A single-clock enable divider steps through the digit slots. The displayed
// digits, the sign and the overflow flag are swapped in only at frame
// boundaries, so one scan frame never mixes old and new values.
module seg_scan_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_SLOTS = 256
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_load,
  input  logic [15:0] i_bcd,
  input  logic        i_neg,
  input  logic        i_ovf,
  input  logic        i_blank_lz,
  output logic [6:0]  o_seg,
  output logic [3:0]  o_an,
  output logic        o_blink
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_SLOTS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_SLOTS - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Scan control
  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_idx;        // slot shown at the next tick
  logic [BLK_W-1:0] r_blk_cnt;    // frames elapsed in the current blink half-period
  logic             r_phase_on;

  // Values captured by i_load, waiting for the next frame boundary
  logic [15:0] r_pend_bcd;
  logic        r_pend_neg;
  logic        r_pend_ovf;
  logic        r_pend_blz;

  // Values driving the frame currently on the display
  logic [15:0] r_act_bcd;
  logic        r_act_neg;
  logic        r_act_ovf;
  logic        r_act_blz;

  // Registered outputs
  logic [6:0] r_seg;
  logic [3:0] r_an;
  logic       r_blink;

  logic             w_tick;
  logic             w_frame;
  logic [15:0]      w_nxt_bcd;
  logic             w_nxt_neg;
  logic             w_nxt_ovf;
  logic             w_nxt_blz;
  logic [BLK_W-1:0] w_blk_cnt_nxt;
  logic             w_phase_nxt;
  logic [3:0]       w_digit;
  logic             w_zf1;
  logic             w_zf2;
  logic             w_zf3;
  logic             w_blank_here;
  logic [1:0]       w_minus_pos;
  logic [3:0]       w_an_onehot;
  logic [6:0]       w_seg_nxt;
  logic [3:0]       w_an_nxt;

  // Active-low g..a pattern for one BCD digit; codes 10-15 stay dark.
  function automatic logic [6:0] dec_digit(input logic [3:0] d);
    case (d)
      4'd0:    dec_digit = 7'b1000000;
      4'd1:    dec_digit = 7'b1111001;
      4'd2:    dec_digit = 7'b0100100;
      4'd3:    dec_digit = 7'b0110000;
      4'd4:    dec_digit = 7'b0011001;
      4'd5:    dec_digit = 7'b0010010;
      4'd6:    dec_digit = 7'b0000010;
      4'd7:    dec_digit = 7'b1111000;
      4'd8:    dec_digit = 7'b0000000;
      4'd9:    dec_digit = 7'b0010000;
      default: dec_digit = SEG_BLANK;
    endcase
  endfunction

  // Letter of "OVER" for a slot; slot 3 is the leftmost digit.
  function automatic logic [6:0] ovf_letter(input logic [1:0] slot);
    case (slot)
      2'd3:    ovf_letter = 7'b1000000;  // O
      2'd2:    ovf_letter = 7'b1000001;  // V
      2'd1:    ovf_letter = 7'b0000110;  // E
      default: ovf_letter = 7'b0001000;  // R
    endcase
  endfunction

  assign w_tick  = (r_div_cnt == DIV_LAST);
  assign w_frame = w_tick && (r_idx == 2'd0);

  // Values that will drive the slot about to be shown; a load on the boundary
  // edge itself bypasses the pending registers so it lands in this frame.
  assign w_nxt_bcd = w_frame ? (i_load ? i_bcd      : r_pend_bcd) : r_act_bcd;
  assign w_nxt_neg = w_frame ? (i_load ? i_neg      : r_pend_neg) : r_act_neg;
  assign w_nxt_ovf = w_frame ? (i_load ? i_ovf      : r_pend_ovf) : r_act_ovf;
  assign w_nxt_blz = w_frame ? (i_load ? i_blank_lz : r_pend_blz) : r_act_blz;

  // Blink phase advances once per frame so the whole word blinks as a unit;
  // it restarts "on" at the frame where overflow first becomes active.
  always_comb begin
    w_blk_cnt_nxt = r_blk_cnt;
    w_phase_nxt   = r_phase_on;
    if (!w_nxt_ovf) begin
      w_blk_cnt_nxt = '0;
      w_phase_nxt   = 1'b1;
    end else if (w_frame) begin
      if (!r_act_ovf) begin
        w_blk_cnt_nxt = '0;
        w_phase_nxt   = 1'b1;
      end else if (r_blk_cnt == BLK_LAST) begin
        w_blk_cnt_nxt = '0;
        w_phase_nxt   = ~r_phase_on;
      end else begin
        w_blk_cnt_nxt = r_blk_cnt + BLK_W'(1);
      end
    end
  end

  // Leading-zero and minus-sign placement for the slot about to be shown.
  always_comb begin
    w_digit     = w_nxt_bcd[{r_idx, 2'b00} +: 4];
    w_zf3       = (w_nxt_bcd[15:12] == 4'd0);
    w_zf2       = w_zf3 && (w_nxt_bcd[11:8] == 4'd0);
    w_zf1       = w_zf2 && (w_nxt_bcd[7:4] == 4'd0);
    w_minus_pos = w_zf1 ? 2'd1 : (w_zf2 ? 2'd2 : (w_zf3 ? 2'd3 : 2'd0));
    case (r_idx)
      2'd1:    w_blank_here = w_zf1;
      2'd2:    w_blank_here = w_zf2;
      2'd3:    w_blank_here = w_zf3;
      default: w_blank_here = 1'b0;
    endcase
    w_an_onehot = ~(4'b0001 << r_idx);
  end

  // Segment/anode pattern for the slot about to be shown.
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_an_nxt  = 4'hF;
    if (w_nxt_ovf) begin
      if (w_phase_nxt) begin
        w_seg_nxt = ovf_letter(r_idx);
        w_an_nxt  = w_an_onehot;
      end
    end else begin
      w_an_nxt = w_an_onehot;
      if (w_nxt_neg && (w_minus_pos != 2'd0) && (r_idx == w_minus_pos)) begin
        w_seg_nxt = SEG_MINUS;
      end else if (w_nxt_blz && w_blank_here) begin
        w_seg_nxt = SEG_BLANK;
      end else begin
        w_seg_nxt = dec_digit(w_digit);
      end
    end
  end

  // Divider, slot scan, input latching, blink state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_div_cnt  <= '0;
      r_idx      <= 2'd0;
      r_blk_cnt  <= '0;
      r_phase_on <= 1'b1;
      r_pend_bcd <= 16'h0000;
      r_pend_neg <= 1'b0;
      r_pend_ovf <= 1'b0;
      r_pend_blz <= 1'b0;
      r_act_bcd  <= 16'h0000;
      r_act_neg  <= 1'b0;
      r_act_ovf  <= 1'b0;
      r_act_blz  <= 1'b0;
      r_seg      <= SEG_BLANK;
      r_an       <= 4'hF;
      r_blink    <= 1'b0;
    end else begin
      r_div_cnt  <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      r_blk_cnt  <= w_blk_cnt_nxt;
      r_phase_on <= w_phase_nxt;
      if (i_load) begin
        r_pend_bcd <= i_bcd;
        r_pend_neg <= i_neg;
        r_pend_ovf <= i_ovf;
        r_pend_blz <= i_blank_lz;
      end
      if (w_frame) begin
        r_act_bcd <= w_nxt_bcd;
        r_act_neg <= w_nxt_neg;
        r_act_ovf <= w_nxt_ovf;
        r_act_blz <= w_nxt_blz;
      end
      if (w_tick) begin
        r_idx   <= r_idx + 2'd1;
        r_seg   <= w_seg_nxt;
        r_an    <= w_an_nxt;
        r_blink <= w_nxt_ovf && w_phase_nxt;
      end
    end
  end

  assign o_seg   = r_seg;
  assign o_an    = r_an;
  assign o_blink = r_blink;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with REFRESH_DIV=4, BLINK_SLOTS=2.
module tb_seg_scan_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;
  localparam logic [6:0] LO = 7'b1000000;
  localparam logic [6:0] LV = 7'b1000001;
  localparam logic [6:0] LE = 7'b0000110;
  localparam logic [6:0] LR = 7'b0001000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd = 16'h0000;
  logic        neg = 1'b0;
  logic        ovf = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        blink;

  int checks = 0;
  int errors = 0;

  seg_scan_display #(.REFRESH_DIV(4), .BLINK_SLOTS(2)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_load(load), .i_bcd(bcd), .i_neg(neg),
    .i_ovf(ovf), .i_blank_lz(blank_lz), .o_seg(seg), .o_an(an), .o_blink(blink)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] e_an,
                       input logic [6:0] e_seg, input logic e_bl);
    checks++;
    assert ({an, seg, blink} === {e_an, e_seg, e_bl}) else begin
      errors++;
      $error("FAIL %s an/seg/blink=%b/%b/%b expected %b/%b/%b",
             tag, an, seg, blink, e_an, e_seg, e_bl);
    end
  endtask

  // Starts right after a slot-3 tick (or a reset release); any load set by
  // the caller is applied on the first edge only.
  task automatic run_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic lit, input logic bl);
    logic [6:0] e;
    for (int k = 0; k < 4; k++) begin
      step();
      load = 1'b0;
      repeat (3) step();
      e = (k == 0) ? s0 : (k == 1) ? s1 : (k == 2) ? s2 : s3;
      if (lit) check($sformatf("%s_s%0d", tag, k), ~(4'b0001 << k), e, bl);
      else     check($sformatf("%s_s%0d", tag, k), 4'hF, BL, 1'b0);
    end
  endtask

  task automatic set_in(input logic [15:0] b, input logic n, input logic o, input logic z);
    load = 1'b1; bcd = b; neg = n; ovf = o; blank_lz = z;
  endtask

  initial begin
    repeat (10) step();
    check("reset", 4'hF, BL, 1'b0);

    resetn = 1'b1;
    repeat (3) step();
    check("pre_first_tick", 4'hF, BL, 1'b0);
    step();
    check("first_s0", 4'b1110, S0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      repeat (4) step();
      check($sformatf("first_s%0d", k), ~(4'b0001 << k), S0, 1'b0);
    end

    set_in(16'h0042, 1'b0, 1'b0, 1'b1);
    run_frame("lz_0042", S2, S4, BL, BL, 1'b1, 1'b0);
    set_in(16'h0042, 1'b0, 1'b0, 1'b0);
    run_frame("nolz_0042", S2, S4, S0, S0, 1'b1, 1'b0);
    set_in(16'h0005, 1'b1, 1'b0, 1'b1);
    run_frame("neg_lz_0005", S5, MI, BL, BL, 1'b1, 1'b0);
    set_in(16'h1005, 1'b1, 1'b0, 1'b1);
    run_frame("neg_1005", S5, S0, S0, S1, 1'b1, 1'b0);
    set_in(16'h0005, 1'b1, 1'b0, 1'b0);
    run_frame("neg_nolz_0005", S5, MI, S0, S0, 1'b1, 1'b0);
    set_in(16'h00AF, 1'b0, 1'b0, 1'b0);
    run_frame("code_af", BL, BL, S0, S0, 1'b1, 1'b0);
    set_in(16'h0000, 1'b1, 1'b0, 1'b1);
    run_frame("neg_zero", S0, MI, BL, BL, 1'b1, 1'b0);

    set_in(16'h1234, 1'b1, 1'b1, 1'b1);
    run_frame("ovf_f0", LR, LE, LV, LO, 1'b1, 1'b1);
    run_frame("ovf_f1", LR, LE, LV, LO, 1'b1, 1'b1);
    run_frame("ovf_f2", BL, BL, BL, BL, 1'b0, 1'b0);
    run_frame("ovf_f3", BL, BL, BL, BL, 1'b0, 1'b0);
    run_frame("ovf_f4", LR, LE, LV, LO, 1'b1, 1'b1);
    set_in(16'h0042, 1'b0, 1'b0, 1'b1);
    run_frame("ovf_clear", S2, S4, BL, BL, 1'b1, 1'b0);

    // Mid-frame load after slot 1 is lit: slots 2,3 keep the old frame.
    repeat (4) step();
    check("mid_s0", 4'b1110, S2, 1'b0);
    repeat (4) step();
    check("mid_s1", 4'b1101, S4, 1'b0);
    set_in(16'h0099, 1'b0, 1'b0, 1'b0);
    step();
    load = 1'b0;
    repeat (3) step();
    check("mid_s2_old", 4'b1011, BL, 1'b0);
    repeat (4) step();
    check("mid_s3_old", 4'b0111, BL, 1'b0);
    run_frame("mid_new", S9, S9, S0, S0, 1'b1, 1'b0);

    // Load on the frame-boundary edge itself.
    repeat (3) step();
    set_in(16'h0357, 1'b0, 1'b0, 1'b0);
    step();
    load = 1'b0;
    check("wrap_s0", 4'b1110, S7, 1'b0);
    for (int k = 1; k < 4; k++) begin
      repeat (4) step();
      check($sformatf("wrap_s%0d", k), ~(4'b0001 << k),
            (k == 1) ? S5 : (k == 2) ? S3 : S0, 1'b0);
    end
    run_frame("wrap_hold", S7, S5, S3, S0, 1'b1, 1'b0);

    // Reset in the middle of a blinking overflow frame.
    set_in(16'h0000, 1'b0, 1'b1, 1'b0);
    run_frame("rst_ovf", LR, LE, LV, LO, 1'b1, 1'b1);
    repeat (4) step();
    check("rst_ovf_lit", 4'b1110, LR, 1'b1);
    resetn = 1'b0;
    step();
    check("rst_mid_blink", 4'hF, BL, 1'b0);
    step();
    resetn = 1'b1;
    run_frame("after_rst", S0, S0, S0, S0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
